// File: rtl/arb_requester.sv
// Purpose: requester agent for one round-robin arbiter port; queues words, requests the bus, sends one word per grant.
// Latency: a push gives Req on the next cycle; a Grant in cycle k puts the word on the bus in cycle k+1.
// Backpressure: full is high at DEPTH words and a push while full is dropped. Optional macro ARB_REQ_SPURIOUS_CHK_EN adds spurious_grant.
module arb_requester #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       Req,
    input  logic                       Grant,
    output logic                       bus_valid,
    output logic [DATA_W-1:0]          bus_data,
`ifdef ARB_REQ_SPURIOUS_CHK_EN
    output logic                       spurious_grant,
`endif
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [7:0]          wait_cnt;
    logic                push_ok, pop;

    // A push is taken only when there is room before this cycle's pop; the XFER cycle always pops the head.
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign push_ok = push & ~full;
    assign pop     = (state == XFER);
    assign cnt_nxt = cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

    // Next state: request while words are pending, one transfer cycle per grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cnt != '0 || push_ok) state_nxt = REQ;
            REQ:  if (Grant) state_nxt = XFER;
            XFER: state_nxt = (cnt_nxt != '0) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and FIFO pointers/occupancy; reset discards all queued words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Registered bus-side outputs follow the state being entered; the head word is captured on entry to XFER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Req       <= 1'b0;
            bus_valid <= 1'b0;
            bus_data  <= '0;
        end else begin
            Req       <= (state_nxt == REQ);
            bus_valid <= (state_nxt == XFER);
            if (state_nxt == XFER) bus_data <= mem[rd_ptr];
        end
    end

    // Starvation watch: count grant-less REQ cycles, saturate at TIMEOUT, latch the error when it is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state != REQ) begin
            if (state_nxt == REQ) wait_cnt <= '0;
        end else if (Grant) begin
            wait_cnt <= '0;
        end else if (wait_cnt != TMO) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == TMO) timeout_err <= 1'b1;
        end
    end

`ifdef ARB_REQ_SPURIOUS_CHK_EN
    // Sticky flag for a grant arriving when no request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     spurious_grant <= 1'b0;
        else if (Grant && state != REQ) spurious_grant <= 1'b1;
    end
`endif

endmodule
